force_pwm_driver: RTL and testbench
===================================

Name: force_pwm_driver

Overview:
- Downstream stage of the neural controller. Consumes the signed 16-bit force command and drives an H-bridge with two complementary-gated PWM outputs.
- Converts force to magnitude and direction, applies a deadband, saturation and shoot-through dead time, and runs a watchdog on the command stream.
- Emits a period-start strobe so the sampling/inference chain can align to the PWM frame.

Parameters:
- CNT_W, 10, width of the PWM period counter.
- PERIOD, 1024, PWM period in clk cycles (≤ 2^CNT_W).
- DUTY_SHIFT, 5, right shift from |force| to duty counts.
- DEADBAND, 64, |force| below this gives duty 0.
- DEADTIME, 16, cycles both outputs are held low after a direction reversal.
- WDOG_PERIODS, 4, consecutive periods without a command before fault.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- force_in  in  16  signed force command, same Q format as the controller output.
- force_valid  in  1  one-cycle strobe; force_in is sampled when high.
- pwm_a  out  1  forward leg gate.
- pwm_b  out  1  reverse leg gate.
- dir  out  1  applied direction, 0 = forward, 1 = reverse.
- duty_applied  out  CNT_W  duty of the current period.
- period_start  out  1  high in the first cycle of each period.
- wdog_fault  out  1  command watchdog tripped.

Behaviour:
- Reset is async on rst_n low. It clears cnt, pending, duty_applied, dir, pwm_a, pwm_b, period_start, wdog_fault and the watchdog counter to 0, and sets state to IDLE.
- cnt runs 0..PERIOD-1 and wraps. The boundary cycle is cnt == PERIOD-1. period_start is high exactly when cnt == 0, including the first cycle after reset release.
- Capture: force_valid loads the pending register. If several strobes arrive in one period, the last one wins. A strobe on the boundary cycle is bypassed directly into the load, so it is used for the next period.
- Magnitude:
  - mag = |force|, computed in 17 bits; -32768 saturates to 32767.
  - If mag < DEADBAND, duty = 0.
  - Otherwise duty = min(mag >> DUTY_SHIFT, PERIOD-1).
- Direction: new_dir = sign bit of the command. dir changes only when the loaded duty is nonzero; with duty 0, dir holds.
- Load at the boundary: duty_applied, dir and state update so they are valid from cnt == 0. No mid-period change is allowed (glitch-free).
- States:
  - IDLE: after reset, and whenever no command has ever arrived. Outputs low. Goes to RUN at the first boundary with a captured command.
  - RUN: active leg is high while cnt < duty_applied. The inactive leg stays low.
  - DEAD: entered at a boundary where dir flips. Both legs are low while cnt < DEADTIME; the active leg is then high while DEADTIME ≤ cnt < duty_applied. Goes to RUN at the next boundary.
  - FAULT: both legs are forced low immediately and wdog_fault = 1. Left on the next force_valid: wdog_fault clears in the following cycle and the command loads at the next boundary as usual. The first load after FAULT always passes through DEAD if dir differs from the last applied dir.
- pwm_a and pwm_b are registered, decoded from next-cnt, so each is high for exactly the stated cycle counts. pwm_a and pwm_b are never high in the same cycle; this is an invariant with a bench assertion.
- Watchdog:
  - The counter increments at each boundary where the period saw no force_valid, and resets on any force_valid.
  - When it reaches WDOG_PERIODS at a boundary, the block enters FAULT in the next cycle (cnt == 0).
  - cnt keeps running in FAULT, so period_start continues.
- Async reset mid-period: outputs go low immediately and cnt restarts at 0 after release. No partial pulse is allowed.

Decomposition:
- Package pendulum_pkg holds:
  - force_t (signed 16);
  - state enum {IDLE, RUN, DEAD, FAULT};
  - default constants for PERIOD, DEADTIME, DUTY_SHIFT, DEADBAND and WDOG_PERIODS.
- One natural sub-module, force_to_duty: a combinational function of force giving {duty, dir, zero}. It covers abs, saturation, deadband, shift and clamp.
- The counter, FSM, watchdog and output registers stay in the top module.

Test Plan:
- Case 1, forward command: reset, then force +16384 valid at cnt 100. From the next cnt == 0, pwm_a is high 512 cycles per period, pwm_b = 0, dir = 0, duty_applied = 512.
- Case 2, full reverse with dead time: after case 1, force -32768. In the next period both legs are low for 16 cycles, then pwm_b is high for 1007 cycles, dir = 1. In the following period pwm_b is high 1023 cycles.
- Case 3, deadband: force +50 → duty 0, both legs low, dir unchanged. Then force -40 → no dead time is inserted, because dir does not change.
- Case 4, watchdog trip and recovery: four full periods with no strobe → wdog_fault = 1 at cnt == 0 and outputs low. Then force +3200 → wdog_fault clears, and from the next period pwm_a is high 100 cycles.
- Case 5, boundary bypass and last-wins: strobe +8192 then +4096 in the same period → duty 128. A strobe on the cnt == 1023 cycle takes effect at cnt == 0 of the next period.
- Case 6, reset mid-operation: assert rst_n low at cnt 300 during a high pulse → pwm_a drops in the same cycle. After release, cnt = 0, period_start = 1, state is IDLE and both legs stay low.

Source files
------------

// File: rtl/pendulum_pkg.sv
// pendulum_pkg: shared types and default constants for the force PWM driver
package pendulum_pkg;
    typedef logic signed [15:0] force_t;
    typedef enum logic [1:0] {IDLE, RUN, DEAD, FAULT} state_t;
    localparam int DEF_CNT_W        = 10;
    localparam int DEF_PERIOD       = 1024;
    localparam int DEF_DUTY_SHIFT   = 5;
    localparam int DEF_DEADBAND     = 64;
    localparam int DEF_DEADTIME     = 16;
    localparam int DEF_WDOG_PERIODS = 4;
endpackage

// File: rtl/force_to_duty.sv
// force_to_duty: signed force command to PWM duty, direction and zero flag
module force_to_duty
    import pendulum_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PERIOD     = DEF_PERIOD,
    parameter int DUTY_SHIFT = DEF_DUTY_SHIFT,
    parameter int DEADBAND   = DEF_DEADBAND
) (
    input  force_t           force_in,
    output logic [CNT_W-1:0] duty,
    output logic             dir,
    output logic             zero
);
    logic [16:0] mag;
    logic [16:0] mag_sat;
    logic [16:0] steps;
    // abs with -32768 pinned to full scale, then deadband, shift and clamp to the period
    always_comb begin
        mag     = force_in[15] ? 17'd0 - {force_in[15], force_in} : {1'b0, force_in};
        mag_sat = (mag > 17'd32767) ? 17'd32767 : mag;
        steps   = mag_sat >> DUTY_SHIFT;
        zero    = mag_sat < 17'(DEADBAND);
        dir     = force_in[15];
        duty    = zero ? '0 : ((steps > 17'(PERIOD - 1)) ? CNT_W'(PERIOD - 1) : steps[CNT_W-1:0]);
    end
endmodule

// File: rtl/force_pwm_driver.sv
// force_pwm_driver: force command to H-bridge PWM with deadband, dead time and command watchdog
module force_pwm_driver
    import pendulum_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int PERIOD       = DEF_PERIOD,
    parameter int DUTY_SHIFT   = DEF_DUTY_SHIFT,
    parameter int DEADBAND     = DEF_DEADBAND,
    parameter int DEADTIME     = DEF_DEADTIME,
    parameter int WDOG_PERIODS = DEF_WDOG_PERIODS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] force_in,
    input  logic               force_valid,
    output logic               pwm_a,
    output logic               pwm_b,
    output logic               dir,
    output logic [CNT_W-1:0]   duty_applied,
    output logic               period_start,
    output logic               wdog_fault
);
    localparam int WD_W = $clog2(WDOG_PERIODS + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d, duty_applied_q, duty_applied_d, new_duty;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    force_t           pend_q, pend_d, load_force;
    state_t           state_q, state_d;
    logic             started_q, pend_new_q, pend_new_d, dir_q, dir_d;
    logic             pwm_a_q, pwm_a_d, pwm_b_q, pwm_b_d, period_start_q, period_start_d;
    logic             wdog_fault_q, wdog_fault_d, new_dir, new_zero, bnd, load, flip, on;

    // a strobe on the boundary cycle bypasses the pending register straight into the load
    assign load_force = force_valid ? force_in : pend_q;

    force_to_duty #(
        .CNT_W     (CNT_W),
        .PERIOD    (PERIOD),
        .DUTY_SHIFT(DUTY_SHIFT),
        .DEADBAND  (DEADBAND)
    ) u_ftd (
        .force_in(load_force),
        .duty    (new_duty),
        .dir     (new_dir),
        .zero    (new_zero)
    );

    // next counter, capture, watchdog and boundary load; outputs decoded from the next state
    always_comb begin
        bnd            = started_q && (cnt_q == CNT_W'(PERIOD - 1));
        cnt_d          = (!started_q || bnd) ? '0 : cnt_q + CNT_W'(1);
        load           = bnd && (force_valid || pend_new_q);
        flip           = !new_zero && (new_dir != dir_q);
        pend_d         = force_valid ? force_in : pend_q;
        pend_new_d     = !bnd && (force_valid || pend_new_q);
        wd_cnt_d       = force_valid ? '0 : wd_cnt_q;
        wdog_fault_d   = wdog_fault_q && !force_valid;
        state_d        = state_q;
        duty_applied_d = duty_applied_q;
        dir_d          = dir_q;
        if (load) begin
            duty_applied_d = new_duty;
            dir_d          = new_zero ? dir_q : new_dir;
            state_d        = (state_q == IDLE || !flip) ? RUN : DEAD;
        end else if (bnd && (state_q == RUN || state_q == DEAD)) begin
            wd_cnt_d     = wd_cnt_q + WD_W'(1);
            wdog_fault_d = wd_cnt_d == WD_W'(WDOG_PERIODS);
            state_d      = wdog_fault_d ? FAULT : RUN;
        end
        on             = (state_d == RUN || (state_d == DEAD && cnt_d >= CNT_W'(DEADTIME)))
                         && (cnt_d < duty_applied_d);
        pwm_a_d        = on && !dir_d;
        pwm_b_d        = on && dir_d;
        period_start_d = cnt_d == '0;
    end

    // state registers; reset drops the gates at once and restarts the frame at cnt 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            started_q      <= 1'b0;
            pend_q         <= '0;
            pend_new_q     <= 1'b0;
            wd_cnt_q       <= '0;
            state_q        <= IDLE;
            duty_applied_q <= '0;
            dir_q          <= 1'b0;
            wdog_fault_q   <= 1'b0;
            pwm_a_q        <= 1'b0;
            pwm_b_q        <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            started_q      <= 1'b1;
            pend_q         <= pend_d;
            pend_new_q     <= pend_new_d;
            wd_cnt_q       <= wd_cnt_d;
            state_q        <= state_d;
            duty_applied_q <= duty_applied_d;
            dir_q          <= dir_d;
            wdog_fault_q   <= wdog_fault_d;
            pwm_a_q        <= pwm_a_d;
            pwm_b_q        <= pwm_b_d;
            period_start_q <= period_start_d;
        end
    end

    assign pwm_a        = pwm_a_q;
    assign pwm_b        = pwm_b_q;
    assign dir          = dir_q;
    assign duty_applied = duty_applied_q;
    assign period_start = period_start_q;
    assign wdog_fault   = wdog_fault_q;
endmodule

// File: tb/tb_force_pwm_driver.sv
// tb_force_pwm_driver: per-period scoreboard bench for force_pwm_driver
module tb_force_pwm_driver;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] force_in = '0;
    logic               force_valid = 1'b0;
    logic               pwm_a, pwm_b, dir, period_start, wdog_fault;
    logic [9:0]         duty_applied;

    typedef struct {int a; int b; int first; int duty; int dir; int flt;} exp_t;
    typedef struct {int pos; int val;} str_t;
    exp_t sb[$];
    str_t strq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    force_pwm_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .force_in    (force_in),
        .force_valid (force_valid),
        .pwm_a       (pwm_a),
        .pwm_b       (pwm_b),
        .dir         (dir),
        .duty_applied(duty_applied),
        .period_start(period_start),
        .wdog_fault  (wdog_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // both legs on together would short the bridge
    always @(negedge clk) assert (!(pwm_a && pwm_b)) else chk("overlap", 1, 0);

    task automatic push(input int a, input int b, input int first, input int duty, input int d, input int flt);
        exp_t e;
        e.a = a; e.b = b; e.first = first; e.duty = duty; e.dir = d; e.flt = flt;
        sb.push_back(e);
    endtask

    task automatic strobe(input int pos, input int val);
        str_t s;
        s.pos = pos; s.val = val;
        strq.push_back(s);
    endtask

    // starts at the negedge of a cnt==0 cycle, ends at the negedge of the next one
    task automatic run_period(input string tag);
        int a = 0, b = 0, first = -1, flt = 0, ps = 0, d0, r0;
        exp_t e;
        d0 = int'(duty_applied);
        r0 = int'(dir);
        for (int i = 0; i < 1024; i++) begin
            if (pwm_a) a++;
            if (pwm_b) b++;
            if ((pwm_a || pwm_b) && first < 0) first = i;
            if (wdog_fault) flt++;
            if (period_start) ps += (i == 0) ? 1 : 100;
            force_valid = 1'b0;
            foreach (strq[k]) if (strq[k].pos == i) begin
                force_valid = 1'b1;
                force_in    = 16'(strq[k].val);
            end
            @(negedge clk);
        end
        force_valid = 1'b0;
        strq.delete();
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_a_hi"}, a, e.a);
        chk({tag, "_b_hi"}, b, e.b);
        chk({tag, "_first_on"}, first, e.first);
        chk({tag, "_duty"}, d0, e.duty);
        chk({tag, "_dir"}, r0, e.dir);
        chk({tag, "_fault_cyc"}, flt, e.flt);
        chk({tag, "_pstart"}, ps, 1);
        chk({tag, "_pstart_next"}, int'(period_start), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pwm_a", int'(pwm_a), 0);
        chk("rst_pwm_b", int'(pwm_b), 0);
        chk("rst_pstart", int'(period_start), 0);
        chk("rst_wdog", int'(wdog_fault), 0);
        chk("rst_duty", int'(duty_applied), 0);
        chk("rst_dir", int'(dir), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_pstart", int'(period_start), 1);

        push(0, 0, -1, 0, 0, 0);
        strobe(100, 16384);  push(512, 0, 0, 512, 0, 0);        run_period("c1_idle");
        strobe(200, -32768); push(0, 1007, 16, 1023, 1, 0);     run_period("c1_fwd");
        push(0, 1023, 0, 1023, 1, 0);                           run_period("c2_dead");
        strobe(10, 50);      push(0, 0, -1, 0, 1, 0);           run_period("c2_full");
        strobe(500, -40);    push(0, 0, -1, 0, 1, 0);           run_period("c3_db_pos");
        strobe(50, 8192); strobe(600, 4096); push(112, 0, 16, 128, 0, 0); run_period("c3_db_neg");
        strobe(1023, 16384); push(512, 0, 0, 512, 0, 0);        run_period("c5_last_wins");
        push(512, 0, 0, 512, 0, 0);                             run_period("c5_bypass");
        push(512, 0, 0, 512, 0, 0);                             run_period("c4_quiet1");
        push(512, 0, 0, 512, 0, 0);                             run_period("c4_quiet2");
        push(0, 0, -1, 512, 0, 301);                            run_period("c4_quiet3");
        strobe(300, 3200);   push(100, 0, 0, 100, 0, 0);        run_period("c4_fault");
        strobe(5, 16384);                                       run_period("c4_recover");

        repeat (300) @(negedge clk);
        chk("c6_pulse_before", int'(pwm_a), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("c6_pwm_a_drop", int'(pwm_a), 0);
        chk("c6_pwm_b_drop", int'(pwm_b), 0);
        chk("c6_duty_clr", int'(duty_applied), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("c6_rel_pstart", int'(period_start), 1);
        chk("c6_rel_pwm_a", int'(pwm_a), 0);
        push(0, 0, -1, 0, 0, 0);                                run_period("c6_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
